nn_deriv_epoch_ctrl: RTL and testbench
======================================

Name: nn_deriv_epoch_ctrl

Overview:
Epoch sequencer for a bank of N_LANES burst-gate derivative units in the stochastic NN backprop path.
- Clears the units' history windows and lets them fill for MEMSIZE cycles (warm-up).
- Then opens a measurement window of STREAM_LEN cycles, counting derivative-stream ones per lane.
- Reports completion through a START/BUSY/DONE handshake.
- Counts are read back through a lane-select mux.

Parameters:
N_LANES, 4, number of derivative lanes sequenced and counted
NB_SEL, 2, width of lane-select port
MEMSIZE, 6, history depth of the derivative units; warm-up length in cycles
NB_LEN, 16, width of stream-length port and run counter
NB_CNT, 16, width of each per-lane ones counter

Ports:
CLK  input  1  system clock, all state on rising edge
INIT  input  1  reset, synchronous, active-low
START  input  1  begin epoch; sampled only in IDLE
STREAM_LEN  input  NB_LEN  measurement length; latched when START is accepted
ZP  input  N_LANES  derivative bitstreams from the lanes
LANE_SEL  input  NB_SEL  selects the counter driven on CNT_OUT
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse at end of epoch
DERIV_CLR  output  1  clear pulse to the derivative units' INIT
DERIV_EN  output  1  clock-enable to the derivative units
RUN_VALID  output  1  high while ZP is being accumulated
CNT_OUT  output  NB_CNT  ones count of the selected lane

Behaviour:
- Reset (INIT=0 at a rising edge):
  - state IDLE; all counters, len_q and the phase counter cleared.
  - BUSY/DONE/DERIV_CLR/DERIV_EN/RUN_VALID = 0.
  - A reset mid-epoch aborts to IDLE with no DONE pulse.
- Outputs are Moore decodes of the state register (no combinational path from START or ZP), except CNT_OUT.
- States:
  - IDLE:
    - START=1 with STREAM_LEN!=0: latch len_q, go to CLEAR.
    - START=1 with STREAM_LEN==0: go to FIN directly. Counters are left unchanged.
  - CLEAR, 1 cycle:
    - DERIV_CLR=1, DERIV_EN=0.
    - All lane counters zeroed at the end of this cycle.
    - Go to WARM.
  - WARM, exactly MEMSIZE cycles: DERIV_EN=1, RUN_VALID=0, ZP ignored. Go to RUN.
  - RUN, exactly len_q cycles:
    - DERIV_EN=1, RUN_VALID=1.
    - At each edge ending a RUN cycle, cnt[i] += ZP[i] for every lane.
    - Go to FIN.
  - FIN, 1 cycle: DONE=1, DERIV_EN=0, BUSY=1. Go to IDLE.
- Timing: START high at edge t gives
  - CLEAR in cycle t+1;
  - WARM in cycles t+2 .. t+1+MEMSIZE;
  - RUN in cycles t+2+MEMSIZE .. t+1+MEMSIZE+L;
  - DONE in cycle t+2+MEMSIZE+L.
- START outside IDLE is ignored. It is not queued.
- START held high through FIN: the new epoch is accepted at the first IDLE edge. This gives one IDLE cycle between epochs.
- STREAM_LEN changes after acceptance have no effect.
- Counters hold their values after FIN until the next CLEAR or reset.
- CNT_OUT is a combinational mux: cnt[LANE_SEL]. It is 0 when LANE_SEL >= N_LANES.
- Counter width rule: default wraps modulo 2^NB_CNT. NB_LEN > NB_CNT is legal.
- The phase counter is NB_LEN wide and is shared by WARM and RUN. MEMSIZE must be < 2^NB_LEN.

Optional Feature:
Macro NN_DERIV_SAT_EN.
- Defined: each lane counter saturates at all-ones and stays there until CLEAR or reset.
- Not defined: counters wrap modulo 2^NB_CNT.
- No port change in either case.

Test Plan:
- Reset then START with STREAM_LEN=10, ZP=4'b1111 constant, MEMSIZE=6:
  - DERIV_CLR high 1 cycle; DERIV_EN high 16 cycles; RUN_VALID high 10 cycles.
  - DONE in cycle 18 after START; every CNT_OUT=10.
- STREAM_LEN=8, ZP[0] toggling 1,0 starting at the first RUN cycle, ZP[3]=0, ZP[1]=ZP[2]=1; ZP=4'b1111 during WARM:
  - cnt0=4, cnt1=8, cnt2=8, cnt3=0.
  - WARM ones are not counted.
- START with STREAM_LEN=0: no CLEAR, DERIV_EN never high, DONE one cycle after START, prior counts unchanged.
- START pulsed again during RUN: ignored, epoch length unchanged.
  - START held continuously: DONE pulses spaced exactly MEMSIZE+L+3 cycles apart.
- INIT low for 1 cycle mid-RUN: all outputs 0 next cycle, no DONE, counters 0. A new START then runs normally.
- NB_CNT=4, STREAM_LEN=20, ZP=all ones: CNT_OUT=4 without NN_DERIV_SAT_EN, 15 with it.
  - LANE_SEL=3 with N_LANES=3 gives CNT_OUT=0.

Source files
------------

// File: rtl/nn_deriv_epoch_ctrl.sv
// Epoch sequencer for burst-gate derivative lanes: clear, warm-up, counted run, done.
// Define NN_DERIV_SAT_EN to make the per-lane ones counters saturate instead of wrap.
module nn_deriv_epoch_ctrl #(
  parameter int N_LANES = 4,
  parameter int NB_SEL  = 2,
  parameter int MEMSIZE = 6,
  parameter int NB_LEN  = 16,
  parameter int NB_CNT  = 16
) (
  input  logic              CLK,
  input  logic              INIT,
  input  logic              START,
  input  logic [NB_LEN-1:0] STREAM_LEN,
  input  logic [N_LANES-1:0] ZP,
  input  logic [NB_SEL-1:0] LANE_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic              DERIV_CLR,
  output logic              DERIV_EN,
  output logic              RUN_VALID,
  output logic [NB_CNT-1:0] CNT_OUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WARM,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [NB_LEN-1:0] WARM_LAST = NB_LEN'(MEMSIZE - 1);
  localparam bit NO_WARM = (MEMSIZE == 0);

  state_t state_q, state_d;
  logic [NB_LEN-1:0] len_q, len_d;
  logic [NB_LEN-1:0] ph_q, ph_d;
  logic [NB_CNT-1:0] cnt_q [N_LANES];
  logic [NB_CNT-1:0] cnt_d [N_LANES];

  always_ff @(posedge CLK) begin
    if (!INIT) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ph_q    <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    DERIV_CLR = 1'b0;
    DERIV_EN  = 1'b0;
    RUN_VALID = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (STREAM_LEN != '0) begin
            len_d   = STREAM_LEN;
            state_d = S_CLEAR;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_CLEAR: begin
        BUSY      = 1'b1;
        DERIV_CLR = 1'b1;
        ph_d      = '0;
        for (int i = 0; i < N_LANES; i++)
          cnt_d[i] = '0;
        state_d = NO_WARM ? S_RUN : S_WARM;
      end
      S_WARM: begin
        BUSY     = 1'b1;
        DERIV_EN = 1'b1;
        if (ph_q == WARM_LAST) begin
          ph_d    = '0;
          state_d = S_RUN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RUN: begin
        BUSY      = 1'b1;
        DERIV_EN  = 1'b1;
        RUN_VALID = 1'b1;
        for (int i = 0; i < N_LANES; i++) begin
`ifdef NN_DERIV_SAT_EN
          if (ZP[i] && (cnt_q[i] != '1))
            cnt_d[i] = cnt_q[i] + 1'b1;
`else
          cnt_d[i] = cnt_q[i] + NB_CNT'(ZP[i]);
`endif
        end
        if (ph_q == len_q - 1'b1) begin
          ph_d    = '0;
          state_d = S_FIN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unpopulated select codes read as zero.
  always_comb begin
    CNT_OUT = '0;
    for (int i = 0; i < N_LANES; i++)
      if (LANE_SEL == NB_SEL'(i))
        CNT_OUT = cnt_q[i];
  end

endmodule

// File: tb/tb_nn_deriv_epoch_ctrl.sv
// Directed bench for nn_deriv_epoch_ctrl: per-cycle phase decode checks,
// count scoreboard popped on DONE; second instance covers narrow counters.
module tb_nn_deriv_epoch_ctrl;

  localparam int M = 6;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic [15:0] slen = '0;
  logic [3:0]  zp = '0;
  logic [1:0]  sel = '0;
  logic [1:0]  sel2 = '0;
  logic        busy, done, clr, en, rv;
  logic [15:0] cnt;
  logic        busy2, done2, clr2, en2, rv2;
  logic [3:0]  cnt2;

  int vectors = 0;
  int errs = 0;

  typedef struct packed {
    logic [3:0][15:0] c;
    logic [2:0][3:0]  c2;
  } exp_t;

  exp_t q[$];
  logic [15:0] m  [4];
  logic [3:0]  m2 [3];

  localparam logic [4:0] E_IDLE  = 5'b00000;
  localparam logic [4:0] E_CLEAR = 5'b10100;
  localparam logic [4:0] E_WARM  = 5'b10010;
  localparam logic [4:0] E_RUN   = 5'b10011;
  localparam logic [4:0] E_FIN   = 5'b11000;

  always #5 clk = ~clk;

  nn_deriv_epoch_ctrl dut (
    .CLK(clk), .INIT(init), .START(start), .STREAM_LEN(slen),
    .ZP(zp), .LANE_SEL(sel), .BUSY(busy), .DONE(done),
    .DERIV_CLR(clr), .DERIV_EN(en), .RUN_VALID(rv), .CNT_OUT(cnt)
  );

  nn_deriv_epoch_ctrl #(
    .N_LANES(3), .NB_SEL(2), .MEMSIZE(M), .NB_LEN(16), .NB_CNT(4)
  ) dut2 (
    .CLK(clk), .INIT(init), .START(start), .STREAM_LEN(slen),
    .ZP(zp[2:0]), .LANE_SEL(sel2), .BUSY(busy2), .DONE(done2),
    .DERIV_CLR(clr2), .DERIV_EN(en2), .RUN_VALID(rv2), .CNT_OUT(cnt2)
  );

  function automatic logic [3:0] inc2(logic [3:0] v, logic b);
`ifdef NN_DERIV_SAT_EN
    return (b && v != 4'hF) ? v + 4'd1 : v;
`else
    return v + {3'b0, b};
`endif
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < 4; i++) e.c[i] = m[i];
    for (int i = 0; i < 3; i++) e.c2[i] = m2[i];
    return e;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 4; i++) m[i] = '0;
    for (int i = 0; i < 3; i++) m2[i] = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(string tag, logic [4:0] e);
    chk(tag, {27'b0, busy, done, clr, en, rv}, {27'b0, e});
  endtask

  task automatic chk_counts(exp_t e);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1 chk($sformatf("cnt%0d", i), {16'b0, cnt}, {16'b0, e.c[i]});
    end
    for (int i = 0; i < 3; i++) begin
      sel2 = 2'(i);
      #1 chk($sformatf("cnt2_%0d", i), {28'b0, cnt2}, {28'b0, e.c2[i]});
    end
    sel2 = 2'd3;
    #1 chk("cnt2_sel3", {28'b0, cnt2}, 32'd0);
  endtask

  // mode 0: all ones; 1: lane0 toggles, lanes1/2 high, lane3 low; 2: zeros
  task automatic epoch(int len, int mode, bit restart);
    int kfin, r;
    logic [4:0] es;
    logic [3:0] z;
    exp_t e;
    tick();
    chk_out("pre_idle", E_IDLE);
    start = 1'b1;
    slen = 16'(len);
    zp = 4'hF;
    kfin = (len == 0) ? 1 : M + 2 + len;
    if (len == 0) q.push_back(snap());
    for (int k = 1; k <= kfin; k++) begin
      tick();
      start = restart && (k == M + 3);
      slen = 16'(len + 7);
      if (len == 0) es = E_FIN;
      else if (k == 1) es = E_CLEAR;
      else if (k <= M + 1) es = E_WARM;
      else if (k <= M + 1 + len) es = E_RUN;
      else es = E_FIN;
      chk_out($sformatf("phase L=%0d k=%0d", len, k), es);
      if (es == E_CLEAR) zero_model();
      if (es == E_RUN) begin
        r = k - (M + 2);
        case (mode)
          0: z = 4'hF;
          1: z = {1'b0, 1'b1, 1'b1, (r % 2 == 0)};
          default: z = 4'h0;
        endcase
        zp = z;
        for (int i = 0; i < 4; i++) m[i] = m[i] + {15'b0, z[i]};
        for (int i = 0; i < 3; i++) m2[i] = inc2(m2[i], z[i]);
        if (k == M + 1 + len) q.push_back(snap());
      end else begin
        zp = 4'hF;
      end
      if (k == kfin) begin
        e = q.pop_front();
        if (done) chk_counts(e);
        else chk("done_seen", {31'b0, done}, 32'd1);
      end
    end
    start = 1'b0;
    zp = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, pulses;
    zero_model();
    init = 1'b0;
    tick();
    tick();
    chk_out("reset_out", E_IDLE);
    chk_counts(snap());
    init = 1'b1;

    epoch(10, 0, 1'b0);
    epoch(8, 1, 1'b0);
    epoch(0, 0, 1'b0);
    epoch(5, 0, 1'b1);

    tick();
    start = 1'b1;
    slen = 16'd3;
    zp = 4'h0;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 80 && pulses < 3; c++) begin
      tick();
      if (done) begin
        if (last >= 0) chk("done_spacing", 32'(c - last), 32'(M + 3 + 3));
        last = c;
        pulses++;
      end
    end
    chk("held_pulses", 32'(pulses), 32'd3);
    start = 1'b0;
    zero_model();

    tick();
    start = 1'b1;
    slen = 16'd10;
    zp = 4'hF;
    for (int k = 1; k <= M + 4; k++) begin
      tick();
      start = 1'b0;
    end
    chk_out("midrun", E_RUN);
    init = 1'b0;
    tick();
    init = 1'b1;
    chk_out("after_abort", E_IDLE);
    zero_model();
    chk_counts(snap());
    tick();
    chk("no_done_after_abort", {31'b0, done}, 32'd0);
    zp = 4'h0;

    epoch(10, 0, 1'b0);
    epoch(20, 0, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
